// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The RF_WB_SCOREBOARD_EN build option is consumed by rf_writeback_arbiter.
package rf_pkg;

   localparam int RF_NUM_REGS             = 32;
   localparam int RF_ADDR_W               = $clog2(RF_NUM_REGS);
   localparam int RF_DATA_W               = 32;
   localparam int RF_STARVE_LIMIT_DEFAULT = 4;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO for M-unit results: full/empty flags, head peek and a
// per-slot destination view for the busy mask.
module rf_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [AW-1:0]             push_rd,
   input  logic [DW-1:0]             push_data,
   input  logic                      pop,
   output logic                      full,
   output logic                      empty,
   output logic [AW-1:0]             head_rd,
   output logic [DW-1:0]             head_data,
   output logic [DEPTH-1:0][AW-1:0]  entry_rd,
   output logic [DEPTH-1:0]          entry_valid
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] rd_mem   [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW:0]   wptr;
   logic [PW:0]   rptr;
   logic [PW:0]   count;

   // The extra pointer bit separates full (MSBs differ) from empty.
   assign empty     = (wptr == rptr);
   assign full      = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
   assign count     = wptr - rptr;
   assign head_rd   = rd_mem[rptr[PW-1:0]];
   assign head_data = data_mem[rptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) wptr <= wptr + 1'b1;
         if (pop && !empty) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         rd_mem[wptr[PW-1:0]]   <= push_rd;
         data_mem[wptr[PW-1:0]] <= push_data;
      end
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      logic [PW-1:0] off;
      entry_rd    = '0;
      entry_valid = '0;
      off         = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off            = PW'(i) - rptr[PW-1:0];
         entry_rd[i]    = rd_mem[i];
         entry_valid[i] = ({1'b0, off} < count);
      end
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges pipeline writeback and buffered M-unit results into one registered
// RF write per cycle. Define RF_WB_SCOREBOARD_EN to generate busy_mask_o.
module rf_writeback_arbiter
   import rf_pkg::*;
#(
   parameter int NUMBER_OF_REGISTERS = RF_NUM_REGS,
   parameter int DATA_WIDTH          = RF_DATA_W,
   parameter int FIFO_DEPTH          = 2,
   parameter int STARVE_LIMIT        = RF_STARVE_LIMIT_DEFAULT,
   localparam int AW                 = $clog2(NUMBER_OF_REGISTERS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pipe_valid_i,
   output logic                           pipe_ready_o,
   input  logic [AW-1:0]                  pipe_rd_i,
   input  logic [DATA_WIDTH-1:0]          pipe_data_i,
   input  logic                           md_valid_i,
   output logic                           md_ready_o,
   input  logic [AW-1:0]                  md_rd_i,
   input  logic [DATA_WIDTH-1:0]          md_data_i,
   output logic                           rd_we_o,
   output logic [AW-1:0]                  rd_address_o,
   output logic [DATA_WIDTH-1:0]          rd_data_o,
   output logic [NUMBER_OF_REGISTERS-1:0] busy_mask_o
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   // Handshakes: a transfer happens in any cycle where valid and ready are both
   // high; valid never depends combinationally on ready.
   logic                             fifo_full;
   logic                             fifo_empty;
   logic                             fifo_push;
   logic [AW-1:0]                    head_rd;
   logic [DATA_WIDTH-1:0]            head_data;
   logic [FIFO_DEPTH-1:0][AW-1:0]    entry_rd;
   logic [FIFO_DEPTH-1:0]            entry_valid;
   logic [CW-1:0]                    starve_cnt;
   logic                             force_grant;
   logic                             fifo_grant;
   logic                             pipe_grant;

   assign md_ready_o   = !fifo_full;
   assign fifo_push    = md_valid_i && !fifo_full && (md_rd_i != '0);
   assign force_grant  = !fifo_empty && (starve_cnt == CW'(STARVE_LIMIT));
   assign pipe_ready_o = !force_grant;
   assign pipe_grant   = pipe_valid_i && !force_grant;
   assign fifo_grant   = force_grant || (!fifo_empty && !pipe_valid_i);

   rf_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (AW),
      .DW    (DATA_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (fifo_push),
      .push_rd     (md_rd_i),
      .push_data   (md_data_i),
      .pop         (fifo_grant),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .entry_rd    (entry_rd),
      .entry_valid (entry_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (fifo_grant) begin
         starve_cnt <= '0;
      end else if (!fifo_empty && (starve_cnt != CW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Writes to x0 still load the register but never raise the enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_we_o      <= 1'b0;
         rd_address_o <= '0;
         rd_data_o    <= '0;
      end else begin
         rd_we_o <= 1'b0;
         if (pipe_grant) begin
            rd_we_o      <= (pipe_rd_i != '0);
            rd_address_o <= pipe_rd_i;
            rd_data_o    <= pipe_data_i;
         end else if (fifo_grant) begin
            rd_we_o      <= (head_rd != '0);
            rd_address_o <= head_rd;
            rd_data_o    <= head_data;
         end
      end
   end

`ifdef RF_WB_SCOREBOARD_EN
   always_comb begin
      busy_mask_o = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i]) busy_mask_o[entry_rd[i]] = 1'b1;
      end
      if (rd_we_o) busy_mask_o[rd_address_o] = 1'b1;
      busy_mask_o[0] = 1'b0;
   end
`else
   logic unused_sb;
   assign unused_sb   = ^{entry_rd, entry_valid};
   assign busy_mask_o = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: reset, both write paths, starvation,
// FIFO back-pressure and ordering, x0 writes and mid-operation reset.
module tb_rf_writeback_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 32;
`ifdef RF_WB_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          pipe_valid_i;
   logic          pipe_ready_o;
   logic [AW-1:0] pipe_rd_i;
   logic [DW-1:0] pipe_data_i;
   logic          md_valid_i;
   logic          md_ready_o;
   logic [AW-1:0] md_rd_i;
   logic [DW-1:0] md_data_i;
   logic          rd_we_o;
   logic [AW-1:0] rd_address_o;
   logic [DW-1:0] rd_data_o;
   logic [NR-1:0] busy_mask_o;

   int total = 0;
   int bad   = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] obs_q[$];

   always #5 clk = ~clk;

   rf_writeback_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_valid_i (pipe_valid_i),
      .pipe_ready_o (pipe_ready_o),
      .pipe_rd_i    (pipe_rd_i),
      .pipe_data_i  (pipe_data_i),
      .md_valid_i   (md_valid_i),
      .md_ready_o   (md_ready_o),
      .md_rd_i      (md_rd_i),
      .md_data_i    (md_data_i),
      .rd_we_o      (rd_we_o),
      .rd_address_o (rd_address_o),
      .rd_data_o    (rd_data_o),
      .busy_mask_o  (busy_mask_o)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      pipe_valid_i = 1'b0;
      pipe_rd_i    = '0;
      pipe_data_i  = '0;
      md_valid_i   = 1'b0;
      md_rd_i      = '0;
      md_data_i    = '0;
   endtask

   task automatic drive_pipe(input logic [AW-1:0] rd, input logic [DW-1:0] data);
      pipe_valid_i = 1'b1;
      pipe_rd_i    = rd;
      pipe_data_i  = data;
   endtask

   task automatic drive_md(input logic [AW-1:0] rd, input logic [DW-1:0] data);
      md_valid_i = 1'b1;
      md_rd_i    = rd;
      md_data_i  = data;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      total++;
      if ({rd_we_o, rd_address_o, rd_data_o} !== '0) begin
         bad++;
         $display("FAIL reset_out: got we=%0b addr=%0d data=%h, want all 0", rd_we_o, rd_address_o, rd_data_o);
      end
      total++;
      if (busy_mask_o !== '0) begin
         bad++;
         $display("FAIL reset_busy: got %h, want 0", busy_mask_o);
      end
      total++;
      if (md_ready_o !== 1'b1 || pipe_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got md=%0b pipe=%0b, want 1 1", md_ready_o, pipe_ready_o);
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_pipe_write();
      drive_pipe(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      total++;
      if (pipe_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL pipe_ready: got %0b, want 1", pipe_ready_o);
      end
      next_cycle();
      drive_idle();
      @(negedge clk);
      total++;
      if (rd_we_o !== 1'b1 || rd_address_o !== 5'd5 || rd_data_o !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL pipe_write: got we=%0b addr=%0d data=%h, want 1 5 deadbeef", rd_we_o, rd_address_o, rd_data_o);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (rd_we_o !== 1'b0 || rd_address_o !== 5'd5 || rd_data_o !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL pipe_hold: got we=%0b addr=%0d data=%h, want 0 5 deadbeef", rd_we_o, rd_address_o, rd_data_o);
      end
      next_cycle();
   endtask

   task automatic test_md_latency();
      logic [1:0] exp_we [4];
      logic       exp_busy [4];
      exp_we   = '{1'b0, 1'b0, 1'b1, 1'b0};
      exp_busy = '{1'b0, SB, SB, 1'b0};
      drive_md(5'd7, 32'h12);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            total++;
            if (md_ready_o !== 1'b1) begin
               bad++;
               $display("FAIL md_ready: got %0b, want 1", md_ready_o);
            end
         end
         total++;
         if (rd_we_o !== exp_we[c][0]) begin
            bad++;
            $display("FAIL md_latency c%0d: got we=%0b, want %0b", c, rd_we_o, exp_we[c][0]);
         end
         total++;
         if (busy_mask_o[7] !== exp_busy[c]) begin
            bad++;
            $display("FAIL md_busy c%0d: got %0b, want %0b", c, busy_mask_o[7], exp_busy[c]);
         end
         if (c == 2) begin
            total++;
            if (rd_address_o !== 5'd7 || rd_data_o !== 32'h12) begin
               bad++;
               $display("FAIL md_write: got addr=%0d data=%h, want 7 12", rd_address_o, rd_data_o);
            end
         end
         next_cycle();
         drive_idle();
      end
   endtask

   task automatic test_starvation();
      drive_pipe(5'd1, 32'd100);
      drive_md(5'd9, 32'h99);
      next_cycle();
      md_valid_i = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         // Cycle 6 repeats cycle 5's request because it was refused then.
         pipe_data_i = (k == 6) ? 32'd105 : 32'd100 + k;
         @(negedge clk);
         total++;
         if (pipe_ready_o !== (k != 5)) begin
            bad++;
            $display("FAIL starve_ready k%0d: got %0b, want %0b", k, pipe_ready_o, (k != 5));
         end
         total++;
         if (k == 6) begin
            if (rd_we_o !== 1'b1 || rd_address_o !== 5'd9 || rd_data_o !== 32'h99) begin
               bad++;
               $display("FAIL starve_force: got we=%0b addr=%0d data=%h, want 1 9 99", rd_we_o, rd_address_o, rd_data_o);
            end
         end else if (rd_we_o !== 1'b1 || rd_address_o !== 5'd1 || rd_data_o !== 32'd99 + k) begin
            bad++;
            $display("FAIL starve_pipe k%0d: got we=%0b addr=%0d data=%0d, want 1 1 %0d", k, rd_we_o, rd_address_o, rd_data_o, 99 + k);
         end
         next_cycle();
      end
      drive_idle();
      @(negedge clk);
      total++;
      if (rd_we_o !== 1'b1 || rd_address_o !== 5'd1 || rd_data_o !== 32'd105) begin
         bad++;
         $display("FAIL starve_resume: got we=%0b addr=%0d data=%0d, want 1 1 105", rd_we_o, rd_address_o, rd_data_o);
      end
      next_cycle();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [AW+DW-1:0] md_list [3];
      logic             exp_md_ready [8];
      int               md_idx;
      logic             accepted;
      md_list      = '{{5'd10, 32'hA0}, {5'd11, 32'hB0}, {5'd12, 32'hC0}};
      exp_md_ready = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(md_list[i]);
      md_idx = 0;
      for (int c = 1; c <= 21; c++) begin
         if (c <= 18) drive_pipe(5'd2, 32'h200);
         else pipe_valid_i = 1'b0;
         if (md_idx < 3) drive_md(md_list[md_idx][AW+DW-1:DW], md_list[md_idx][DW-1:0]);
         else md_valid_i = 1'b0;
         @(negedge clk);
         accepted = md_valid_i && md_ready_o;
         if (rd_we_o === 1'b1 && rd_address_o >= 5'd10) obs_q.push_back({rd_address_o, rd_data_o});
         if (c <= 7) begin
            total++;
            if (md_ready_o !== exp_md_ready[c]) begin
               bad++;
               $display("FAIL b2b_md_ready c%0d: got %0b, want %0b", c, md_ready_o, exp_md_ready[c]);
            end
         end
         if (c <= 18) begin
            total++;
            if (pipe_ready_o !== !(c == 6 || c == 11 || c == 16)) begin
               bad++;
               $display("FAIL b2b_pipe_ready c%0d: got %0b, want %0b", c, pipe_ready_o, !(c == 6 || c == 11 || c == 16));
            end
         end
         next_cycle();
         if (accepted) md_idx++;
      end
      drive_idle();
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL b2b_count: got %0d md writes, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         logic [AW+DW-1:0] e;
         logic [AW+DW-1:0] o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL b2b_order: got rd=%0d data=%h, want rd=%0d data=%h", o[AW+DW-1:DW], o[DW-1:0], e[AW+DW-1:DW], e[DW-1:0]);
         end
      end
   endtask

   task automatic test_x0();
      drive_pipe(5'd0, 32'h55);
      drive_md(5'd0, 32'h66);
      @(negedge clk);
      total++;
      if (pipe_ready_o !== 1'b1 || md_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL x0_handshake: got pipe=%0b md=%0b, want 1 1", pipe_ready_o, md_ready_o);
      end
      next_cycle();
      drive_idle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (rd_we_o !== 1'b0 || busy_mask_o !== '0) begin
            bad++;
            $display("FAIL x0_nowrite c%0d: got we=%0b busy=%h, want 0 0", c, rd_we_o, busy_mask_o);
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      drive_pipe(5'd3, 32'h33);
      drive_md(5'd20, 32'h20);
      next_cycle();
      drive_md(5'd21, 32'h21);
      next_cycle();
      md_valid_i = 1'b0;
      @(negedge clk);
      total++;
      if (md_ready_o !== 1'b0) begin
         bad++;
         $display("FAIL rmid_full: got md_ready=%0b, want 0", md_ready_o);
      end
      #1 rst = 1'b0;
      drive_idle();
      #1;
      total++;
      if (rd_we_o !== 1'b0 || md_ready_o !== 1'b1 || busy_mask_o !== '0) begin
         bad++;
         $display("FAIL rmid_async: got we=%0b md_ready=%0b busy=%h, want 0 1 0", rd_we_o, md_ready_o, busy_mask_o);
      end
      next_cycle();
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         total++;
         if (rd_we_o !== 1'b0 || md_ready_o !== 1'b1 || busy_mask_o !== '0) begin
            bad++;
            $display("FAIL rmid_stale c%0d: got we=%0b md_ready=%0b busy=%h, want 0 1 0", c, rd_we_o, md_ready_o, busy_mask_o);
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_pipe_write();
      test_md_latency();
      test_starvation();
      test_back_to_back();
      test_x0();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Writer-side front end for the integer register file's single write port. It merges two result sources into one registered write per cycle: the in-order pipeline writeback and the long-latency multiply/divide unit. M-unit results are buffered in a small FIFO. Pipeline results normally win arbitration, but a starvation counter guarantees the buffered M-unit results are eventually written. An optional scoreboard publishes which destination registers still have writes pending.

## Interface
Parameters:
- NUMBER_OF_REGISTERS, 32, register count; address width is $clog2(NUMBER_OF_REGISTERS).
- DATA_WIDTH, 32, result width.
- FIFO_DEPTH, 2, M-unit result buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4, consecutive lost arbitrations before the FIFO head is forced through; ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pipe_valid_i  in  1  pipeline has a writeback this cycle.
- pipe_ready_o  out  1  pipeline writeback accepted this cycle.
- pipe_rd_i  in  addr  pipeline destination register.
- pipe_data_i  in  DATA_WIDTH  pipeline result.
- md_valid_i  in  1  M-unit result valid.
- md_ready_o  out  1  FIFO can accept an M-unit result.
- md_rd_i  in  addr  M-unit destination register.
- md_data_i  in  DATA_WIDTH  M-unit result.
- rd_we_o  out  1  register file write enable (registered).
- rd_address_o  out  addr  register file write address (registered).
- rd_data_o  out  DATA_WIDTH  register file write data (registered).
- busy_mask_o  out  NUMBER_OF_REGISTERS  bit r set while a write to register r is pending.

## Operation
- Handshakes:
  - A transfer occurs when valid and ready are both high in the same cycle.
  - Valid must not depend combinationally on ready.
- md_ready_o = FIFO not full. There is no same-cycle pass-through when full, even if the FIFO pops that cycle.
- M-unit transfers:
  - An accepted M-unit result with rd = 0 is consumed and discarded, never enqueued.
  - All other accepted M-unit results are enqueued, including when the FIFO is empty.
- Arbitration (priority: pipeline, then FIFO head):
  - force = FIFO non-empty AND starve_cnt == STARVE_LIMIT.
  - pipe_ready_o = !force.
  - FIFO head is granted when force is high, or when the FIFO is non-empty and pipe_valid_i is low.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each cycle the FIFO is non-empty and its head is not granted.
  - Clears on any FIFO grant.
- Output register:
  - Loads the granted source's address and data.
  - rd_we_o = 1 only if a source was granted and its rd ≠ 0. A pipeline write to x0 is accepted but produces no write.
  - When nothing is granted, rd_we_o = 0 and address/data hold their previous values.
- FIFO pointers:
  - Wrap modulo FIFO_DEPTH.
  - Full/empty is distinguished by an extra pointer bit.
  - Push and pop in the same cycle leave the occupancy unchanged.
- Reset (asynchronous; may occur mid-operation):
  - FIFO flushed, pointers = 0, starve_cnt = 0.
  - rd_we_o = 0, rd_address_o = 0, rd_data_o = 0, busy_mask_o = 0.
  - Results in flight are lost.

## Timing
- Pipeline path: accepted in cycle N → rd_we_o high in N+1.
- M-unit path: accepted in cycle N → enqueued at the N edge → earliest grant in N+1 → rd_we_o high in N+2.
- Worst-case wait for a FIFO head: STARVE_LIMIT cycles of continuous pipeline traffic, then a forced grant.
- Forced-grant cycle: pipe_ready_o = 0, and the pipeline holds its request.
- busy_mask_o is combinational from FIFO contents plus the output register. It covers every queued entry and the entry in the output register while rd_we_o = 1. Bit 0 is always 0.

## Configuration
- RF_WB_SCOREBOARD_EN defined:
  - busy_mask_o is generated as described under Timing.
  - The issue stage uses it for RAW hazard detection on M-unit destinations.
- RF_WB_SCOREBOARD_EN undefined:
  - busy_mask_o is tied to 0 and the mask logic is removed.
  - The issue stage must stall on any M-unit operation in flight.

## Structure
- Shared package rf_pkg:
  - Register address width constant.
  - wb_req_t struct {rd, data}.
  - Default STARVE_LIMIT.
- One sub-module: rf_wb_fifo, a synchronous FIFO with full/empty flags, a peek-at-head output, and a per-entry rd view for the scoreboard.
- Arbitration, starvation counter and output register live in the top level.

## Test plan
- Reset, then pipeline write rd=5, data=0xDEADBEEF in cycle 1 → rd_we_o=1, rd_address_o=5, rd_data_o=0xDEADBEEF in cycle 2; all outputs 0 during reset.
- M-unit result rd=7, data=0x12 with pipeline idle → rd_we_o high exactly 2 cycles after acceptance; busy_mask_o[7]=1 from the cycle after acceptance until the write cycle ends.
- Pipeline valid every cycle with 1 queued M-unit result and STARVE_LIMIT=4 → FIFO head is written on the 5th cycle with pipe_ready_o=0 that cycle; pipeline resumes the next cycle.
- Three back-to-back M-unit results under continuous pipeline traffic, FIFO_DEPTH=2 → md_ready_o drops after 2 pushes, no entry is lost or reordered, and both pointers wrap correctly.
- Writes to rd=0 from both sources → both handshakes complete, rd_we_o stays 0, busy_mask_o[0]=0.
- Reset asserted while the FIFO is full and a write is pending → rd_we_o=0 and md_ready_o=1 immediately after deassertion; no stale write appears afterwards.
